// File: rtl/fp16_pkg.sv
// -----------------------------------------------------------------------------
// fp16_pkg
// Shared definitions for the fp16 adder pipeline stages:
//   - fp16 word width and the +0 encoding used to pad an odd stream tail
//   - fp16 field positions (sign / biased exponent / mantissa)
//   - state encoding of the pair-forming FSM in fp16add_issue
// No ports (package).
// -----------------------------------------------------------------------------
package fp16_pkg;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_PZERO = 16'h0000;

    // Field layout of an IEEE-754 binary16 word.
    localparam int FP16_SIGN_BIT  = 15;
    localparam int FP16_BEXP_MSB  = 14;
    localparam int FP16_BEXP_LSB  = 10;
    localparam int FP16_BEXP_W    = FP16_BEXP_MSB - FP16_BEXP_LSB + 1;
    localparam int FP16_MANT_MSB  = 9;
    localparam int FP16_MANT_LSB  = 0;
    localparam int FP16_MANT_W    = FP16_MANT_MSB - FP16_MANT_LSB + 1;

    // Pair-forming FSM: either no operand pending, or operand A is held.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        HAVE_A = 1'b1
    } fp16add_state_e;

endpackage

// File: rtl/fp16add_issue_if.sv
// -----------------------------------------------------------------------------
// fp16add_issue_if
// Bundles the stream, adder and result-FIFO signals of fp16add_issue.
//   slave  : view of fp16add_issue (drives o_*, receives i_*)
//   master : view of the environment around it (drives i_*, receives o_*)
// Parameter LVL_W must equal $clog2(DEPTH+1) of the attached fp16add_issue.
// -----------------------------------------------------------------------------
interface fp16add_issue_if
    import fp16_pkg::*;
#(
    parameter int LVL_W = 3
) ();

    // Input word stream
    logic              i_valid;
    logic              o_ready;
    logic [FP16_W-1:0] i_data;
    logic              i_last;
    logic              i_rmode;

    // Adder operand / result side
    logic [FP16_W-1:0] o_add_a;
    logic [FP16_W-1:0] o_add_b;
    logic              o_add_rmode;
    logic [FP16_W-1:0] i_add_res;

    // Result FIFO stream
    logic              o_valid;
    logic              i_ready;
    logic [FP16_W-1:0] o_res;
    logic [LVL_W-1:0]  o_level;

    modport slave (
        input  i_valid, i_data, i_last, i_rmode, i_add_res, i_ready,
        output o_ready, o_add_a, o_add_b, o_add_rmode, o_valid, o_res, o_level
    );

    modport master (
        output i_valid, i_data, i_last, i_rmode, i_add_res, i_ready,
        input  o_ready, o_add_a, o_add_b, o_add_rmode, o_valid, o_res, o_level
    );

endinterface

// File: rtl/fp16_fifo.sv
// -----------------------------------------------------------------------------
// fp16_fifo
// Circular first-word-fall-through FIFO with an occupancy output.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   push, push_data write push_data at the tail (ignored when full and not popping)
//   pop             remove head; ignored when empty
//   head            current head word (all zeros while empty after reset)
//   valid           FIFO non-empty
//   level           number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fp16_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 16,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             valid,
    output logic [LVL_W-1:0] level
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop  = pop && (level_q != '0);
        do_push = push && ((level_q != LVL_W'(DEPTH)) || do_pop);

        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        level_d = level_q;

        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ptr_inc(wr_q);
        end
        if (do_pop) begin
            rd_d = ptr_inc(rd_q);
        end

        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign valid = (level_q != '0);
    assign level = level_q;

endmodule

// File: rtl/fp16add_issue.sv
// -----------------------------------------------------------------------------
// fp16add_issue
// Pairs consecutive fp16 words of a valid/ready stream into (a, b) operands,
// issues them to a fixed-latency adder without backpressure, and collects the
// adder results in an output FIFO. Issue is credit-gated: words are accepted
// only while in-flight results plus stored results stay below DEPTH, so a
// result arriving from the adder always finds room.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   bus         fp16add_issue_if.slave:
//                 i_valid/o_ready/i_data/i_last/i_rmode  input word stream
//                 o_add_a/o_add_b/o_add_rmode            registered adder operands
//                 i_add_res                              adder result (LAT cycles later)
//                 o_valid/i_ready/o_res/o_level          result FIFO stream
// Parameters:
//   LAT    adder latency, operands presented -> result valid
//   DEPTH  result FIFO entries and total credit count (>= 2)
// -----------------------------------------------------------------------------
module fp16add_issue
    import fp16_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fp16add_issue_if.slave      bus
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    // Wide enough to hold level (<= DEPTH) plus every pipe bit (LAT+1).
    localparam int CNT_W = $clog2(DEPTH + LAT + 2);

    fp16add_state_e    state_q, state_d;
    logic [FP16_W-1:0] a_q, a_d;
    logic [FP16_W-1:0] add_a_q, add_a_d;
    logic [FP16_W-1:0] add_b_q, add_b_d;
    logic              add_rmode_q, add_rmode_d;
    logic [LAT:0]      vld_q, vld_d;

    logic              accept;
    logic              issue;
    logic              ready;
    logic [CNT_W-1:0]  used;
    logic [LVL_W-1:0]  fifo_level;

    // Credits in use: results still travelling through the adder plus results
    // already stored. Only registered state feeds this, so o_ready never
    // depends combinationally on i_valid or i_ready.
    always_comb begin
        used = CNT_W'(fifo_level);
        for (int i = 0; i <= LAT; i++) begin
            used = used + CNT_W'(vld_q[i]);
        end
        ready = (used < CNT_W'(DEPTH));
    end

    assign accept = bus.i_valid && ready;

    // Pair-forming FSM and operand registers.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_rmode_d = add_rmode_q;
        issue       = 1'b0;

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_last) begin
                        // Odd tail: pad with +0 so the word passes through the adder.
                        issue       = 1'b1;
                        add_a_d     = bus.i_data;
                        add_b_d     = FP16_PZERO;
                        add_rmode_d = bus.i_rmode;
                    end else begin
                        a_d     = bus.i_data;
                        state_d = HAVE_A;
                    end
                end
                HAVE_A: begin
                    issue       = 1'b1;
                    add_a_d     = a_q;
                    add_b_d     = bus.i_data;
                    add_rmode_d = bus.i_rmode;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Issue-valid pipe: stage 0 is set on the issuing edge; the bit leaving
    // stage LAT marks the edge on which i_add_res holds that pair's sum.
    always_comb begin
        vld_d[0] = issue;
        for (int i = 1; i <= LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= FP16_PZERO;
            add_a_q     <= FP16_PZERO;
            add_b_q     <= FP16_PZERO;
            add_rmode_q <= 1'b0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_rmode_q <= add_rmode_d;
            vld_q       <= vld_d;
        end
    end

    fp16_fifo #(
        .DEPTH (DEPTH),
        .W     (FP16_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_q[LAT]),
        .push_data (bus.i_add_res),
        .pop       (bus.i_ready),
        .head      (bus.o_res),
        .valid     (bus.o_valid),
        .level     (fifo_level)
    );

    assign bus.o_ready     = ready;
    assign bus.o_add_a     = add_a_q;
    assign bus.o_add_b     = add_b_q;
    assign bus.o_add_rmode = add_rmode_q;
    assign bus.o_level     = fifo_level;

endmodule

// File: tb/tb_fp16add_issue.sv
// -----------------------------------------------------------------------------
// tb_fp16add_issue
// Self-checking bench for fp16add_issue (LAT=1, DEPTH=4). A one-cycle adder
// model answers from a small table of known fp16 sums; expected results are
// constants queued when a pair is completed and compared as they leave the FIFO.
// -----------------------------------------------------------------------------
module tb_fp16add_issue;
    import fp16_pkg::*;

    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fp16add_issue_if #(.LVL_W(LVL_W)) bus ();

    fp16add_issue #(
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int max_level = 0;
    logic [15:0] exp_q[$];

    // Known binary16 sums for the operands used below.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h0000) return b;
        if (b == 16'h0000) return a;
        if (a == 16'h7C00 || b == 16'h7C00) return 16'h7C00;
        if (a == 16'h3C00 && b == 16'h3C00) return 16'h4000;
        if ((a == 16'h3C00 && b == 16'h4000) || (a == 16'h4000 && b == 16'h3C00)) return 16'h4200;
        if (a == 16'h4000 && b == 16'h4000) return 16'h4400;
        return 16'hFFFF;
    endfunction

    // Adder with one register stage (LAT = 1).
    always @(posedge clk) bus.i_add_res <= ref_add(bus.o_add_a, bus.o_add_b);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Scoreboard: every pop the DUT will perform on the next edge is compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(bus.o_level) > max_level) max_level = int'(bus.o_level);
            if (bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result got=%0h expected=none", bus.o_res);
                end else begin
                    chk("result", 32'(bus.o_res), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic l, input logic r, output int stalls);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_last  = l;
        bus.i_rmode = r;
        stalls      = 0;
        @(negedge clk);
        while (!bus.o_ready && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (!bus.o_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=stalled expected=accept");
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        bit          single;
        bit          rm;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[4];
    logic [15:0] bp_w[12];
    logic [15:0] bp_exp[6];
    int          st;
    int          total_stalls;
    int          idx;
    bit          acc;

    initial begin
        vecs[0] = '{w0: 16'h3C00, w1: 16'h4000, single: 1'b0, rm: 1'b0, exp: 16'h4200};
        vecs[1] = '{w0: 16'h3C00, w1: 16'h0000, single: 1'b1, rm: 1'b0, exp: 16'h3C00};
        vecs[2] = '{w0: 16'h7C00, w1: 16'h3C00, single: 1'b0, rm: 1'b1, exp: 16'h7C00};
        vecs[3] = '{w0: 16'h4000, w1: 16'h3C00, single: 1'b0, rm: 1'b0, exp: 16'h4200};
        bp_w    = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h4000, 16'h4000, 16'h4000,
                    16'h4000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4000, 16'h4000};
        bp_exp  = '{16'h4000, 16'h4200, 16'h4400, 16'h4200, 16'h4000, 16'h4400};

        bus.i_valid = 1'b0;
        bus.i_data  = 16'h0000;
        bus.i_last  = 1'b0;
        bus.i_rmode = 1'b0;
        bus.i_ready = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_o_level", 32'(bus.o_level), 32'd0);
        chk("rst_o_res", 32'(bus.o_res), 32'h0);
        chk("rst_o_add_a", 32'(bus.o_add_a), 32'h0);
        chk("rst_o_add_b", 32'(bus.o_add_b), 32'h0);
        chk("rst_o_add_rmode", 32'(bus.o_add_rmode), 32'd0);
        chk("rst_o_ready", 32'(bus.o_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic pair with latency and level timing.
        send(16'h3C00, 1'b0, 1'b0, st);
        send(16'h4000, 1'b0, 1'b0, st);
        exp_q.push_back(16'h4200);
        chk("basic_add_a", 32'(bus.o_add_a), 32'h3C00);
        chk("basic_add_b", 32'(bus.o_add_b), 32'h4000);
        @(posedge clk); #1;
        chk("basic_valid_edge1", 32'(bus.o_valid), 32'd0);
        @(posedge clk); #1;
        chk("basic_valid_edge2", 32'(bus.o_valid), 32'd1);
        chk("basic_level_edge2", 32'(bus.o_level), 32'd1);
        chk("basic_res_edge2", 32'(bus.o_res), 32'h4200);
        @(posedge clk); #1;
        chk("basic_level_edge3", 32'(bus.o_level), 32'd0);

        // Table-driven pairs / odd tails.
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].single) begin
                send(vecs[i].w0, 1'b1, vecs[i].rm, st);
            end else begin
                send(vecs[i].w0, 1'b0, 1'b0, st);
                send(vecs[i].w1, 1'b0, vecs[i].rm, st);
            end
            exp_q.push_back(vecs[i].exp);
            chk($sformatf("vec%0d_add_a", i), 32'(bus.o_add_a), 32'(vecs[i].w0));
            chk($sformatf("vec%0d_add_b", i), 32'(bus.o_add_b),
                vecs[i].single ? 32'h0 : 32'(vecs[i].w1));
            chk($sformatf("vec%0d_rmode", i), 32'(bus.o_add_rmode), 32'(vecs[i].rm));
            drain($sformatf("vec%0d_drain", i));
        end

        // Backpressure: downstream stalled, credits must stop acceptance at 8 words.
        bus.i_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 20 && idx < 12; c++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = bp_w[idx];
            bus.i_last  = 1'b0;
            bus.i_rmode = 1'b0;
            @(negedge clk);
            acc = bus.o_ready;
            @(posedge clk);
            if (acc) begin
                idx++;
                if (idx % 2 == 0) exp_q.push_back(bp_exp[idx/2 - 1]);
            end
            #1;
        end
        bus.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_accepted", 32'(idx), 32'd8);
        chk("bp_o_ready", 32'(bus.o_ready), 32'd0);
        chk("bp_o_level", 32'(bus.o_level), 32'd4);
        bus.i_ready = 1'b1;
        for (int k = 8; k < 12; k++) begin
            send(bp_w[k], 1'b0, 1'b0, st);
            if (k % 2 == 1) exp_q.push_back(bp_exp[k/2]);
        end
        drain("bp_drain");

        // Streaming at one word per cycle.
        max_level    = 0;
        total_stalls = 0;
        for (int k = 0; k < 16; k++) begin
            send(16'h3C00, 1'b0, 1'b0, st);
            total_stalls += st;
            if (k % 2 == 1) exp_q.push_back(16'h4000);
        end
        drain("stream_drain");
        chk("stream_stalls", 32'(total_stalls), 32'd0);
        chk("stream_max_level_le2", 32'(max_level <= 2), 32'd1);

        // Reset with operand A held and results pending.
        bus.i_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(16'h3C00, 1'b0, 1'b0, st);
        chk("midrst_busy", 32'(bus.o_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", 32'(bus.o_valid), 32'd0);
        chk("midrst_o_level", 32'(bus.o_level), 32'd0);
        chk("midrst_o_ready", 32'(bus.o_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        send(16'h4000, 1'b0, 1'b0, st);
        send(16'h4000, 1'b0, 1'b0, st);
        exp_q.push_back(16'h4400);
        drain("midrst_drain");
        repeat (4) @(posedge clk);
        #1;
        chk("final_o_valid", 32'(bus.o_valid), 32'd0);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp16add_issue.md
Name: fp16add_issue

Overview:
- Upstream feeder for the fp16 two-input adder pipeline: takes a valid/ready stream of fp16 words and pairs consecutive words into (a, b) operands.
- Issues each pair to the adder, which has no backpressure, and captures the adder results into an output FIFO.
- Issue is credit-gated so results are never dropped.
- Used as the building block of stream reduction, where each pass halves the word count.

Parameters:
- LAT, 1, adder latency in cycles from operands presented on o_add_a/o_add_b to i_add_res valid.
- DEPTH, 4, output FIFO entries; also the total credit count (in-flight plus stored), must be >= 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  input word valid
- o_ready  out  1  input word accepted when i_valid && o_ready
- i_data  in  16  fp16 input word
- i_last  in  1  marks final word of a stream; if it lands in slot A, pair it with +0 (0x0000)
- i_rmode  in  1  rounding mode, sampled with the word that completes a pair
- o_add_a  out  16  adder operand a (registered)
- o_add_b  out  16  adder operand b (registered)
- o_add_rmode  out  1  adder rounding mode (registered)
- i_add_res  in  16  adder result
- o_valid  out  1  FIFO non-empty
- i_ready  in  1  downstream pop when o_valid && i_ready
- o_res  out  16  FIFO head (first-word fall-through)
- o_level  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async assert, sync release) clears everything:
  - state=IDLE; o_add_a/b=16'h0000; o_add_rmode=0
  - valid pipe cleared; FIFO empty; o_valid=0; o_level=0; o_res=16'h0000
  - o_ready=1 after reset.
- In-flight results are discarded on reset, with no partial output.
- Credits:
  - inflight = number of set bits in the issue-valid pipe (length LAT+1).
  - o_ready = (inflight + o_level) < DEPTH, decoded from registered state only.
  - This guarantees a FIFO push never overflows.
- FSM on accepted word:
  - IDLE, i_last=0: store word in slot A, go to HAVE_A. No issue.
  - IDLE, i_last=1: issue (word, 16'h0000), stay IDLE.
  - HAVE_A, any i_last: issue (A, word), go to IDLE.
  - i_last in HAVE_A has no extra effect.
- Issue: on the accepting edge, o_add_a/o_add_b/o_add_rmode load the operands and a 1 enters stage 0 of the valid pipe.
- Operands hold their value until the next issue.
- When a valid bit exits the pipe (LAT+1 edges after the accepting edge), i_add_res is written at the FIFO tail that edge.
- With LAT=1: accept at edge n, operands visible n..n+1, push at edge n+2, so o_valid rises after edge n+2.
- FIFO: circular, wrap at DEPTH.
  - Simultaneous push and pop: o_level unchanged, head advances, tail advances.
  - Pop when empty is ignored.
  - Results leave in issue order.
- Throughput: one pair per 2 accepted words. Sustains 1 word/cycle input when i_ready=1 and DEPTH >= LAT+2.
- Words accepted while o_ready=0 do not occur by definition; i_data is ignored then.
- The block does not inspect fp16 values. NaN/Inf/denormal handling belongs to the adder.

Decomposition:
- Shared package fp16_pkg: FP16_W=16, FP16_PZERO=16'h0000, field widths/offsets (sign 15, bexp 14:10, mant 9:0).
- The same package also holds the FSM state enum {IDLE, HAVE_A}.
- One sub-module: fp16_fifo (DEPTH, 16-bit, first-word fall-through, level output), reusable by other pipeline stages.

Test Plan:
- Basic pair: 0x3C00, 0x4000 accepted with i_ready=1, adder model returns a+b -> o_res=0x4200 two edges after second word, o_level 1 then 0.
- Odd tail: single word 0x3C00 with i_last=1 in IDLE -> issues a=0x3C00, b=0x0000, state stays IDLE, o_res=0x3C00.
- Backpressure: i_ready=0, offer 12 words -> exactly 8 accepted, o_ready=0 once inflight+level=4, o_level=4. Release i_ready -> 4 results in order, then remaining words resume.
- Streaming: i_valid=i_ready=1 for 16 words 0x3C00 -> 8 results of 0x4000, no input stall after reset, o_level never exceeds 2.
- Special passthrough: 0x7C00 + 0x3C00 -> adder result 0x7C00 delivered unchanged. i_rmode=1 on second word -> o_add_rmode=1 during that issue.
- Reset mid-op: assert rst_n=0 with A held and 2 in flight -> o_valid=0, o_level=0, o_ready=1 next cycle. Next pair 0x4000, 0x4000 -> 0x4400 only.
